kb_key_tracker: RTL and testbench



---
 rtl/kb_key_tracker.sv | 190 +++++++++++++++++++
 tb/tb_kb_key_tracker.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/kb_key_tracker.sv
// kb_key_tracker
// Decodes PS/2 scan-code-set-2 make/break sequences, including the E0 extended
// prefix, for up to N_KEYS programmable keys. It keeps the held state of each
// key and raises a one-cycle press or release pulse when that state changes.
//
// Ports:
//   clk              system clock; all state changes on the rising edge
//   reset            asynchronous, active-high; clears all state
//   scan_done_tick   one-cycle strobe; scan_code is valid in that cycle
//   scan_code[7:0]   byte from the PS/2 receiver
//   key_held         bit i is high while the slot i key is down
//   key_press_tick   one-cycle pulse when slot i goes down
//   key_release_tick one-cycle pulse when slot i goes up
//   any_held         OR of key_held
//   last_code[8:0]   {ext, code} of the last completed make or break
//   last_break       high if that sequence was a break
//
// Optional feature, enabled by defining KB_TRACKER_TIMEOUT_EN:
//   a prefix state that receives no byte for TIMEOUT_CYCLES cycles falls back
//   to IDLE. This recovers from bytes lost after a prefix.
//
// Prefix FSM states:
//   state      | meaning
//   ST_IDLE    | no prefix pending
//   ST_EXT     | E0 seen; next code is an extended make
//   ST_BRK     | F0 seen; next code is a break
//   ST_EXT_BRK | E0 and F0 seen; next code is an extended break

module kb_key_tracker #(
   parameter int                    N_KEYS         = 4,
   parameter logic [9*N_KEYS-1:0]   KEY_CODES      = {N_KEYS{9'h000}},
   parameter int                    TIMEOUT_CYCLES = 1_000_000
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              scan_done_tick,
   input  logic [7:0]        scan_code,
   output logic [N_KEYS-1:0] key_held,
   output logic [N_KEYS-1:0] key_press_tick,
   output logic [N_KEYS-1:0] key_release_tick,
   output logic              any_held,
   output logic [8:0]        last_code,
   output logic              last_break
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_EXT     = 2'd1,
      ST_BRK     = 2'd2,
      ST_EXT_BRK = 2'd3
   } state_t;

   localparam logic [7:0] CODE_EXT = 8'hE0;
   localparam logic [7:0] CODE_BRK = 8'hF0;

   state_t              state_q, state_d;
   logic [N_KEYS-1:0]   held_q, held_d;
   logic [N_KEYS-1:0]   press_q, press_d;
   logic [N_KEYS-1:0]   release_q, release_d;
   logic                any_q;
   logic [8:0]          last_code_q;
   logic                last_break_q;

   logic                seq_done;
   logic                seq_ext;
   logic                seq_brk;
   logic [8:0]          seq_code;
   logic                timeout;

`ifdef KB_TRACKER_TIMEOUT_EN
   localparam int            CW       = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   // Counter idles at zero in IDLE and restarts on every byte, so it starts
   // from zero on each entry into a prefix state.
   always_comb begin
      cnt_d = '0;
      if (!scan_done_tick && state_q != ST_IDLE && cnt_q != CNT_LAST)
         cnt_d = cnt_q + 1'b1;
   end

   assign timeout = !scan_done_tick && (state_q != ST_IDLE) && (cnt_q == CNT_LAST);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end
`else
   assign timeout = 1'b0;
`endif

   always_comb begin
      state_d  = state_q;
      seq_done = 1'b0;
      seq_ext  = 1'b0;
      seq_brk  = 1'b0;
      if (scan_done_tick) begin
         case (state_q)
            ST_IDLE: begin
               if (scan_code == CODE_EXT)      state_d = ST_EXT;
               else if (scan_code == CODE_BRK) state_d = ST_BRK;
               else                            seq_done = 1'b1;
            end
            ST_EXT: begin
               if (scan_code == CODE_EXT)      state_d = ST_EXT;
               else if (scan_code == CODE_BRK) state_d = ST_EXT_BRK;
               else begin
                  seq_done = 1'b1;
                  seq_ext  = 1'b1;
                  state_d  = ST_IDLE;
               end
            end
            ST_BRK: begin
               if (scan_code == CODE_BRK)      state_d = ST_BRK;
               else if (scan_code == CODE_EXT) state_d = ST_EXT_BRK;
               else begin
                  seq_done = 1'b1;
                  seq_brk  = 1'b1;
                  state_d  = ST_IDLE;
               end
            end
            default: begin
               if (scan_code == CODE_EXT || scan_code == CODE_BRK) state_d = ST_EXT_BRK;
               else begin
                  seq_done = 1'b1;
                  seq_ext  = 1'b1;
                  seq_brk  = 1'b1;
                  state_d  = ST_IDLE;
               end
            end
         endcase
      end else if (timeout) begin
         state_d = ST_IDLE;
      end
   end

   assign seq_code = {seq_ext, scan_code};

   // Every matching slot acts on its own, so duplicate table entries track
   // together. Slots holding a prefix byte can never be a completed code.
   always_comb begin
      held_d    = held_q;
      press_d   = '0;
      release_d = '0;
      for (int i = 0; i < N_KEYS; i++) begin
         if (seq_done && KEY_CODES[9*i +: 9] == seq_code &&
             KEY_CODES[9*i +: 8] != CODE_EXT && KEY_CODES[9*i +: 8] != CODE_BRK) begin
            if (!seq_brk && !held_q[i]) begin
               held_d[i]  = 1'b1;
               press_d[i] = 1'b1;
            end else if (seq_brk && held_q[i]) begin
               held_d[i]    = 1'b0;
               release_d[i] = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         held_q       <= '0;
         press_q      <= '0;
         release_q    <= '0;
         any_q        <= 1'b0;
         last_code_q  <= 9'h000;
         last_break_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         held_q    <= held_d;
         press_q   <= press_d;
         release_q <= release_d;
         any_q     <= |held_d;
         if (seq_done) begin
            last_code_q  <= seq_code;
            last_break_q <= seq_brk;
         end
      end
   end

   assign key_held         = held_q;
   assign key_press_tick   = press_q;
   assign key_release_tick = release_q;
   assign any_held         = any_q;
   assign last_code        = last_code_q;
   assign last_break       = last_break_q;

endmodule

// File: tb/tb_kb_key_tracker.sv
// Directed bench for kb_key_tracker with four slots:
//   slot 0 = 01B, slot 1 = 023, slot 2 = 01C, slot 3 = E0 1D (9'h11D).
// Inputs change and outputs are sampled on the falling clock edge.

module tb_kb_key_tracker;

   logic       clk = 1'b0;
   logic       reset;
   logic       scan_done_tick;
   logic [7:0] scan_code;
   logic [3:0] key_held;
   logic [3:0] key_press_tick;
   logic [3:0] key_release_tick;
   logic       any_held;
   logic [8:0] last_code;
   logic       last_break;

   int errors = 0;
   int checks = 0;

   kb_key_tracker #(
      .N_KEYS         (4),
      .KEY_CODES      ({9'h11D, 9'h01C, 9'h023, 9'h01B}),
      .TIMEOUT_CYCLES (16)
   ) dut (
      .clk              (clk),
      .reset            (reset),
      .scan_done_tick   (scan_done_tick),
      .scan_code        (scan_code),
      .key_held         (key_held),
      .key_press_tick   (key_press_tick),
      .key_release_tick (key_release_tick),
      .any_held         (any_held),
      .last_code        (last_code),
      .last_break       (last_break)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Called at a falling edge; returns at the next falling edge, after the
   // byte has been taken on the rising edge in between.
   task automatic send(input logic [7:0] b);
      scan_done_tick = 1'b1;
      scan_code      = b;
      @(negedge clk);
      scan_done_tick = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) @(negedge clk);
   endtask

   initial begin
      reset          = 1'b1;
      scan_done_tick = 1'b0;
      scan_code      = 8'h00;
      idle(3);
      chk("rst_held",    32'(key_held),         32'h0);
      chk("rst_press",   32'(key_press_tick),   32'h0);
      chk("rst_release", 32'(key_release_tick), 32'h0);
      chk("rst_any",     32'(any_held),         32'h0);
      chk("rst_code",    32'(last_code),        32'h000);
      chk("rst_brk",     32'(last_break),       32'h0);
      reset = 1'b0;
      idle(1);

      // Plain make of 1C -> slot 2
      send(8'h1C);
      chk("mk1c_held",  32'(key_held),       32'b0100);
      chk("mk1c_press", 32'(key_press_tick), 32'b0100);
      chk("mk1c_any",   32'(any_held),       32'h1);
      chk("mk1c_code",  32'(last_code),      32'h01C);
      chk("mk1c_brk",   32'(last_break),     32'h0);
      idle(1);
      chk("mk1c_pulse_end", 32'(key_press_tick), 32'h0);

      // Typematic repeats: no further press pulses
      for (int r = 0; r < 3; r++) begin
         send(8'h1C);
         chk("rpt_press", 32'(key_press_tick), 32'h0);
         chk("rpt_held",  32'(key_held),       32'b0100);
      end

      // Bytes without the strobe are ignored
      scan_code = 8'h1B;
      idle(2);
      chk("nostb_held", 32'(key_held),  32'b0100);
      chk("nostb_code", 32'(last_code), 32'h01C);

      // Break F0 1C: prefix alone changes nothing, code releases slot 2
      send(8'hF0);
      chk("pfx_held", 32'(key_held),   32'b0100);
      chk("pfx_brk",  32'(last_break), 32'h0);
      send(8'h1C);
      chk("brk1c_rel",  32'(key_release_tick), 32'b0100);
      chk("brk1c_held", 32'(key_held),         32'h0);
      chk("brk1c_any",  32'(any_held),         32'h0);
      chk("brk1c_code", 32'(last_code),        32'h01C);
      chk("brk1c_brk",  32'(last_break),       32'h1);
      idle(1);
      chk("brk1c_rel_end", 32'(key_release_tick), 32'h0);

      // Extended make E0 1D -> slot 3
      send(8'hE0);
      send(8'h1D);
      chk("ext_press", 32'(key_press_tick), 32'b1000);
      chk("ext_held",  32'(key_held),       32'b1000);
      chk("ext_code",  32'(last_code),      32'h11D);
      // Non-extended 1D does not match slot 3
      send(8'h1D);
      chk("plain1d_press", 32'(key_press_tick), 32'h0);
      chk("plain1d_held",  32'(key_held),       32'b1000);
      chk("plain1d_code",  32'(last_code),      32'h01D);
      // Extended break E0 F0 1D
      send(8'hE0);
      send(8'hF0);
      send(8'h1D);
      chk("extbrk_rel",  32'(key_release_tick), 32'b1000);
      chk("extbrk_held", 32'(key_held),         32'h0);
      chk("extbrk_code", 32'(last_code),        32'h11D);
      chk("extbrk_brk",  32'(last_break),       32'h1);

      // Break of a key that is not held
      send(8'hF0);
      send(8'h1B);
      chk("unheld_rel",   32'(key_release_tick), 32'h0);
      chk("unheld_press", 32'(key_press_tick),   32'h0);
      chk("unheld_code",  32'(last_code),        32'h01B);
      chk("unheld_brk",   32'(last_break),       32'h1);

      // Back-to-back makes 23 then 1B
      send(8'h23);
      chk("b2b_press1", 32'(key_press_tick), 32'b0010);
      send(8'h1B);
      chk("b2b_press2", 32'(key_press_tick), 32'b0001);
      chk("b2b_held",   32'(key_held),       32'b0011);
      chk("b2b_any",    32'(any_held),       32'h1);
      chk("b2b_brk",    32'(last_break),     32'h0);

      // Reset mid-prefix with keys held: no release pulse, prefix dropped
      send(8'hE0);
      reset = 1'b1;
      idle(1);
      chk("mrst_held", 32'(key_held),         32'h0);
      chk("mrst_rel",  32'(key_release_tick), 32'h0);
      chk("mrst_any",  32'(any_held),         32'h0);
      chk("mrst_code", 32'(last_code),        32'h000);
      reset = 1'b0;
      idle(1);
      send(8'h1C);
      chk("post_rst_press", 32'(key_press_tick), 32'b0100);
      chk("post_rst_code",  32'(last_code),      32'h01C);

      // Release slot 2, then a stalled F0 prefix followed by 1C
      send(8'hF0);
      send(8'h1C);
      chk("pre_to_held", 32'(key_held), 32'h0);
      send(8'hF0);
      idle(20);
      send(8'h1C);
`ifdef KB_TRACKER_TIMEOUT_EN
      chk("to_press", 32'(key_press_tick), 32'b0100);
      chk("to_held",  32'(key_held),       32'b0100);
      chk("to_brk",   32'(last_break),     32'h0);
`else
      chk("to_press", 32'(key_press_tick), 32'h0);
      chk("to_held",  32'(key_held),       32'h0);
      chk("to_brk",   32'(last_break),     32'h1);
`endif
      chk("to_code", 32'(last_code), 32'h01C);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
